// File: rtl/present_ct_tx.sv
// present_ct_tx
//    Ciphertext output stage for the iterative PRESENT-80 core. Captures each
//    64-bit ciphertext block, holds up to DEPTH blocks in a circular buffer,
//    and serialises them MSB-first as bytes over a valid/ready stream.
//    Blocks that arrive while the buffer is full are dropped, and the sticky
//    ovf flag is set.
//
//    Optional feature macro: PRESENT_TX_CSUM_EN
//       defined   : each frame carries a 9th byte, the XOR of the 8 block bytes
//       undefined : 8-byte frames, no checksum logic
//
//    Parameters
//       DEPTH     number of 64-bit block slots (2 or 4)
//    Ports
//       clk       rising-edge clock, shared with the cipher core
//       rst       synchronous active-high reset
//       ct_data   ciphertext block, bit 0 is the MSB
//       ct_valid  single-cycle strobe qualifying ct_data
//       tx_data   current output byte
//       tx_valid  tx_data is valid
//       tx_ready  downstream accepts the byte when tx_valid is also high
//       tx_last   current byte ends its frame
//       ovf       sticky: a block was dropped
//       level     occupied slots, 0..DEPTH
//
//    state | meaning
//    IDLE  | buffer empty, no byte offered
//    SEND  | head block being serialised, tx_valid high
module present_ct_tx #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:63] ct_data,
   input  logic        ct_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_last,
   output logic        ovf,
   output logic [2:0]  level
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [2:0] LVL_FULL = 3'(DEPTH);

`ifdef PRESENT_TX_CSUM_EN
   localparam int BW = 4;
   localparam logic [BW-1:0] BI_LAST = 4'd8;
`else
   localparam int BW = 3;
   localparam logic [BW-1:0] BI_LAST = 3'd7;
`endif

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic [0:63]     mem [DEPTH];
   logic [PW-1:0]   wp, rp;
   logic [BW-1:0]   bi;
   logic [2:0]      level_d;
   logic [0:63]     head;
   logic [7:0]      head_byte;
   logic            push, pop, drop, full;

   assign head = mem[rp];
   assign full = (level == LVL_FULL);

   // Byte select within the head block; index 0 picks ct_data[0:7].
   assign head_byte = head[{bi[2:0], 3'b000} +: 8];

`ifdef PRESENT_TX_CSUM_EN
   logic [7:0] csum;

   always_comb begin
      csum = 8'h00;
      for (int k = 0; k < 8; k++) begin
         csum = csum ^ head[8*k +: 8];
      end
   end
`endif

   // Outputs come only from registered state (state_q, rp, bi, storage).
   always_comb begin
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = 8'h00;
      if (state_q == SEND) begin
         tx_valid = 1'b1;
         tx_last  = (bi == BI_LAST);
`ifdef PRESENT_TX_CSUM_EN
         tx_data  = (bi == BI_LAST) ? csum : head_byte;
`else
         tx_data  = head_byte;
`endif
      end
   end

   // A pop frees the head slot in the same cycle, so a full buffer can still
   // take a block while its head frame completes.
   assign pop  = tx_valid & tx_ready & tx_last;
   assign push = ct_valid & (~full | pop);
   assign drop = ct_valid & full & ~pop;

   always_comb begin
      level_d = level;
      case ({push, pop})
         2'b10:   level_d = level + 3'd1;
         2'b01:   level_d = level - 3'd1;
         default: level_d = level;
      endcase
      state_d = (level_d != 3'd0) ? SEND : IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wp      <= '0;
         rp      <= '0;
         bi      <= '0;
         level   <= 3'd0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_d;
         level   <= level_d;
         if (push) wp <= wp + 1'b1;
         if (pop) begin
            rp <= rp + 1'b1;
            bi <= '0;
         end else if (tx_valid & tx_ready) begin
            bi <= bi + 1'b1;
         end
         if (drop) ovf <= 1'b1;
      end
   end

   // Block storage is not reset; level and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wp] <= ct_data;
   end

endmodule

// File: tb/tb_present_ct_tx.sv
module tb_present_ct_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:63] ct_data;
   logic        ct_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;
   logic        ovf;
   logic [2:0]  level;

   int vectors = 0;
   int miscompares = 0;

`ifdef PRESENT_TX_CSUM_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   localparam logic [63:0] BLK_A = 64'h0123456789ABCDEF;
   localparam logic [63:0] BLK_B = 64'hFEDCBA9876543210;
   localparam logic [63:0] BLK_C = 64'hDEADBEEFCAFEF00D;
   localparam logic [63:0] BLK_D = 64'h1122334455667788;

   present_ct_tx #(.DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .ct_data  (ct_data),
      .ct_valid (ct_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
      .ovf      (ovf),
      .level    (level)
   );

   always #5 clk = ~clk;

   // Expected byte i of a frame carrying blk: bytes 0..7 MSB first, byte 8 XOR.
   function automatic logic [7:0] exp_byte(input logic [63:0] blk, input int i);
      logic [7:0] x;
      if (i < 8) return blk[63-8*i -: 8];
      x = 8'h00;
      for (int k = 0; k < 8; k++) x = x ^ blk[63-8*k -: 8];
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ct_valid = 1'b0; ct_data = '0; tx_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      vectors++;
      if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
      vectors++;
      if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
      vectors++;
      if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      vectors++;
      if (tx_data !== 8'h00 || tx_last !== 1'b0) begin
         miscompares++; $display("FAIL reset_data_last: got %h/%b expected 00/0", tx_data, tx_last);
      end
   endtask

   task automatic test_single();
      tx_ready = 1'b1;
      ct_data = BLK_A; ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         vectors++;
         if (tx_valid !== 1'b1 || tx_data !== exp_byte(BLK_A, i) || tx_last !== (i == FL-1)) begin
            miscompares++;
            $display("FAIL single_byte%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                     i, tx_valid, tx_data, tx_last, exp_byte(BLK_A, i), (i == FL-1));
         end
         tick();
      end
      vectors++;
      if (level !== 3'd0 || tx_valid !== 1'b0) begin
         miscompares++; $display("FAIL single_drain: got level=%0d v=%b expected 0/0", level, tx_valid);
      end
   endtask

   task automatic test_backpressure();
      tx_ready = 1'b1;
      ct_data = BLK_A; ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (tx_data !== exp_byte(BLK_A, i)) begin
            miscompares++; $display("FAIL bp_pre%0d: got %h expected %h", i, tx_data, exp_byte(BLK_A, i));
         end
         tick();
      end
      tx_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h67 || tx_last !== 1'b0) begin
            miscompares++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b expected v=1 d=67 l=0", c, tx_valid, tx_data, tx_last);
         end
      end
      tx_ready = 1'b1;
      for (int i = 3; i < FL; i++) begin
         vectors++;
         if (tx_valid !== 1'b1 || tx_data !== exp_byte(BLK_A, i) || tx_last !== (i == FL-1)) begin
            miscompares++; $display("FAIL bp_post%0d: got %h/%b expected %h/%b", i, tx_data, tx_last, exp_byte(BLK_A, i), (i == FL-1));
         end
         tick();
      end
      vectors++;
      if (tx_valid !== 1'b0 || level !== 3'd0) begin
         miscompares++; $display("FAIL bp_drain: got v=%b level=%0d expected 0/0", tx_valid, level);
      end
   endtask

   task automatic test_overflow();
      logic [63:0] blk;
      tx_ready = 1'b0;
      ct_valid = 1'b1;
      ct_data = BLK_A; tick();
      ct_data = BLK_B; tick();
      ct_data = BLK_C; tick();
      ct_valid = 1'b0;
      vectors++;
      if (level !== 3'd2 || ovf !== 1'b1) begin
         miscompares++; $display("FAIL ovf_flag: got level=%0d ovf=%b expected 2/1", level, ovf);
      end
      vectors++;
      if (tx_data !== exp_byte(BLK_A, 0)) begin
         miscompares++; $display("FAIL ovf_head: got %h expected %h", tx_data, exp_byte(BLK_A, 0));
      end
      tx_ready = 1'b1;
      for (int f = 0; f < 2; f++) begin
         blk = (f == 0) ? BLK_A : BLK_B;
         for (int i = 0; i < FL; i++) begin
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== exp_byte(blk, i) || tx_last !== (i == FL-1)) begin
               miscompares++; $display("FAIL ovf_f%0d_b%0d: got %h/%b expected %h/%b", f, i, tx_data, tx_last, exp_byte(blk, i), (i == FL-1));
            end
            tick();
         end
      end
      vectors++;
      if (tx_valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b1) begin
         miscompares++; $display("FAIL ovf_after: got v=%b level=%0d ovf=%b expected 0/0/1", tx_valid, level, ovf);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      vectors++;
      if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] blk;
      tx_ready = 1'b0;
      ct_valid = 1'b1;
      ct_data = BLK_A; tick();
      ct_data = BLK_B; tick();
      ct_valid = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < FL; i++) begin
         if (i == FL-1) begin ct_data = BLK_D; ct_valid = 1'b1; end
         vectors++;
         if (tx_data !== exp_byte(BLK_A, i)) begin
            miscompares++; $display("FAIL b2b_a%0d: got %h expected %h", i, tx_data, exp_byte(BLK_A, i));
         end
         tick();
      end
      ct_valid = 1'b0;
      vectors++;
      if (level !== 3'd2 || ovf !== 1'b0) begin
         miscompares++; $display("FAIL b2b_full_coinc: got level=%0d ovf=%b expected 2/0", level, ovf);
      end
      for (int f = 0; f < 2; f++) begin
         blk = (f == 0) ? BLK_B : BLK_D;
         for (int i = 0; i < FL; i++) begin
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== exp_byte(blk, i) || tx_last !== (i == FL-1)) begin
               miscompares++; $display("FAIL b2b_f%0d_b%0d: got v=%b d=%h l=%b expected 1/%h/%b", f, i, tx_valid, tx_data, tx_last, exp_byte(blk, i), (i == FL-1));
            end
            tick();
         end
      end
      vectors++;
      if (level !== 3'd0 || tx_valid !== 1'b0) begin
         miscompares++; $display("FAIL b2b_drain: got level=%0d v=%b expected 0/0", level, tx_valid);
      end
   endtask

   task automatic test_reset_mid();
      tx_ready = 1'b1;
      ct_data = BLK_B; ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      vectors++;
      if (tx_data !== exp_byte(BLK_B, 3)) begin
         miscompares++; $display("FAIL rmid_pre: got %h expected %h", tx_data, exp_byte(BLK_B, 3));
      end
      rst = 1'b1; ct_data = BLK_C; ct_valid = 1'b1;
      tick();
      rst = 1'b0; ct_valid = 1'b0;
      vectors++;
      if (tx_valid !== 1'b0 || level !== 3'd0 || tx_data !== 8'h00) begin
         miscompares++; $display("FAIL rmid_cleared: got v=%b level=%0d d=%h expected 0/0/00", tx_valid, level, tx_data);
      end
      tick();
      vectors++;
      if (tx_valid !== 1'b0) begin
         miscompares++; $display("FAIL rmid_ignored_push: got v=%b expected 0", tx_valid);
      end
      ct_data = BLK_D; ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         vectors++;
         if (tx_valid !== 1'b1 || tx_data !== exp_byte(BLK_D, i) || tx_last !== (i == FL-1)) begin
            miscompares++; $display("FAIL rmid_new%0d: got %h/%b expected %h/%b", i, tx_data, tx_last, exp_byte(BLK_D, i), (i == FL-1));
         end
         tick();
      end
      vectors++;
      if (level !== 3'd0) begin
         miscompares++; $display("FAIL rmid_drain: got level=%0d expected 0", level);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
